// File: rtl/key_debounce_pulse_pkg.sv
// rtl/key_debounce_pulse_pkg.sv - state encoding shared by pushbutton/switch conditioners
package key_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } key_state_t;

  // The debounced level stays asserted while a release is still being qualified.
  function automatic logic key_is_down(input key_state_t s);
    return (s == S_HELD) || (s == S_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_debounce_pulse_sync_2ff.sv
// rtl/key_debounce_pulse_sync_2ff.sv - two-flop metastability synchronizer for async board inputs
module key_debounce_pulse_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - debounced level plus press/release/auto-repeat pulses from a raw active-low key
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic count_en
);
  import key_debounce_pulse_pkg::*;

  localparam longint L_LIMIT = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] L_DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_RPT_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] L_RPT_PERIOD = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] L_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("key_debounce_pulse: CNT_W out of range");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > L_LIMIT) begin : g_bad_debounce
    $error("key_debounce_pulse: DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 0 || REPEAT_DELAY > L_LIMIT) begin : g_bad_delay
    $error("key_debounce_pulse: REPEAT_DELAY out of range");
  end
  if (REPEAT_DELAY != 0 && (REPEAT_PERIOD < 1 || REPEAT_PERIOD > L_LIMIT)) begin : g_bad_period
    $error("key_debounce_pulse: REPEAT_PERIOD out of range");
  end

  logic             w_key_sync;
  logic             w_k_s;
  key_state_t       r_state;
  key_state_t       w_state_next;
  logic [CNT_W-1:0] r_tmr;
  logic [CNT_W-1:0] w_tmr_next;
  logic [CNT_W-1:0] r_rpt;
  logic [CNT_W-1:0] w_rpt_next;
  logic             r_rpt_run;
  logic             w_rpt_run_next;
  logic             w_rpt_evt;
  logic             w_down;
  logic             w_press_evt;
  logic             w_release_evt;

  // Reset loads "released" so leaving reset never looks like a press.
  key_debounce_pulse_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (key_n),
    .o_sync  (w_key_sync)
  );

  assign w_k_s = ~w_key_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_tmr         <= '0;
      r_rpt         <= '0;
      r_rpt_run     <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      count_en      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_tmr         <= w_tmr_next;
      r_rpt         <= w_rpt_next;
      r_rpt_run     <= w_rpt_run_next;
      pressed       <= w_down;
      press_pulse   <= w_press_evt;
      release_pulse <= w_release_evt;
      repeat_pulse  <= w_rpt_evt;
      count_en      <= w_press_evt | w_rpt_evt;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_tmr_next     = r_tmr;
    w_rpt_next     = '0;
    w_rpt_run_next = 1'b0;
    w_rpt_evt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_k_s) begin
          w_state_next = S_PRESS_WAIT;
          w_tmr_next   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_k_s) begin
          w_state_next = S_IDLE;
        end else if (r_tmr == L_DB_LAST) begin
          w_state_next = S_HELD;
        end else begin
          w_tmr_next = r_tmr + L_ONE;
        end
      end
      S_HELD: begin
        if (!w_k_s) begin
          w_state_next = S_RELEASE_WAIT;
          w_tmr_next   = '0;
        end else begin
          // First interval is REPEAT_DELAY, later ones REPEAT_PERIOD; counting restarts at 1 after a pulse.
          w_rpt_run_next = r_rpt_run;
          if (REPEAT_DELAY != 0 && r_rpt == (r_rpt_run ? L_RPT_PERIOD : L_RPT_DELAY)) begin
            w_rpt_evt      = 1'b1;
            w_rpt_next     = L_ONE;
            w_rpt_run_next = 1'b1;
          end else if (r_rpt != L_CNT_MAX) begin
            w_rpt_next = r_rpt + L_ONE;
          end else begin
            w_rpt_next = r_rpt;
          end
        end
      end
      S_RELEASE_WAIT: begin
        if (w_k_s) begin
          w_state_next = S_HELD;
        end else if (r_tmr == L_DB_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_tmr_next = r_tmr + L_ONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    w_down        = key_is_down(r_state);
    w_press_evt   = w_down & ~pressed;
    w_release_evt = ~w_down & pressed;
  end

endmodule
